// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the CNN layer-1/layer-2 datapath.
package cnn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      FETCH,
      PRES,
      DRAIN,
      DONE
   } l1_rd_state_t;

   localparam int unsigned L1_WIN_COLS = 11;
   localparam int unsigned L1_WIN_ROWS = 11;
   localparam int unsigned L1_RD_LAT   = 1;

endpackage

// File: rtl/win_cnt.sv
// Raster-order column/row counter for the 3x3 read windows of one frame.
// Saturates on the final window so the position never runs past the frame.
module win_cnt
   import cnn_pkg::*;
#(
   parameter int unsigned WIN_COLS = L1_WIN_COLS,
   parameter int unsigned WIN_ROWS = L1_WIN_ROWS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] col,
   output logic [3:0] row,
   output logic       last
);

   logic col_end;

   assign col_end = (col == 4'(WIN_COLS - 1));
   assign last    = col_end && (row == 4'(WIN_ROWS - 1));

   // Advance one window per accepted handshake; wrap column into the next row.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col <= '0;
         row <= '0;
      end else if (inc && !last) begin
         if (col_end) begin
            col <= '0;
            row <= row + 4'd1;
         end else begin
            col <= col + 4'd1;
         end
      end
   end

endmodule

// File: rtl/l1_rd_ctrl.sv
// Read-side scheduler for the layer-1 pooled-feature buffer: walks the frame's
// read windows in raster order and hands each one to layer-2 over valid/ready.
module l1_rd_ctrl
   import cnn_pkg::*;
#(
   parameter int unsigned WIN_COLS = L1_WIN_COLS,
   parameter int unsigned WIN_ROWS = L1_WIN_ROWS,
   parameter int unsigned RD_LAT   = L1_RD_LAT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_go,
   input  logic       l1_rd,
   input  logic       win_rdy,
   input  logic       l2_done,
   input  logic       abort,
   output logic       addr_rd_inc,
   output logic       tx_done,
   output logic       win_vld,
   output logic       win_last,
   output logic [3:0] win_col,
   output logic [3:0] win_row,
   output logic       busy,
   output logic       err_ovr
);

   l1_rd_state_t state;
   logic [1:0]   lat_cnt;
   logic         accept;
   logic         cnt_clr;
   logic         cnt_last;

   // Abort takes priority over a same-cycle handshake, so the window is not consumed.
   assign accept      = win_vld & win_rdy & ~abort;
   assign addr_rd_inc = accept;
   assign cnt_clr     = (state == DONE);
   assign win_last    = cnt_last;

   win_cnt #(
      .WIN_COLS(WIN_COLS),
      .WIN_ROWS(WIN_ROWS)
   ) u_win_cnt (
      .clk (clk),
      .rst (rst),
      .inc (accept),
      .clr (cnt_clr),
      .col (win_col),
      .row (win_row),
      .last(cnt_last)
   );

   // Frame sequencer with registered win_vld/tx_done/busy and sticky overrun flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         lat_cnt <= '0;
         win_vld <= 1'b0;
         tx_done <= 1'b0;
         busy    <= 1'b0;
         err_ovr <= 1'b0;
      end else begin
         win_vld <= 1'b0;
         tx_done <= 1'b0;
         if (frame_go && (state != IDLE)) begin
            err_ovr <= 1'b1;
         end
         if (abort && (state != IDLE) && (state != DONE)) begin
            state   <= DONE;
            tx_done <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (frame_go) begin
                     state <= WAIT;
                     busy  <= 1'b1;
                  end
               end
               WAIT: begin
                  if (l1_rd) begin
                     state   <= FETCH;
                     lat_cnt <= 2'(RD_LAT - 1);
                  end
               end
               FETCH: begin
                  if (lat_cnt == '0) begin
                     state   <= PRES;
                     win_vld <= 1'b1;
                  end else begin
                     lat_cnt <= lat_cnt - 2'd1;
                  end
               end
               PRES: begin
                  if (win_rdy) begin
                     state <= cnt_last ? DRAIN : WAIT;
                  end else begin
                     win_vld <= 1'b1;
                  end
               end
               DRAIN: begin
                  if (l2_done) begin
                     state   <= DONE;
                     tx_done <= 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_l1_rd_ctrl.sv
// Self-checking bench for l1_rd_ctrl: a RD_LAT=1 and a RD_LAT=3 instance share stimulus.
module tb_l1_rd_ctrl;

   localparam int C = 11;
   localparam int R = 11;
   localparam int N = C * R;

   logic clk = 1'b0;
   logic rst, frame_go, l1_rd, win_rdy, l2_done, abort;

   logic       a_inc, a_txd, a_vld, a_last, a_busy, a_err;
   logic [3:0] a_col, a_row;
   logic       b_inc, b_txd, b_vld, b_last, b_busy, b_err;
   logic [3:0] b_col, b_row;

   int n_chk  = 0;
   int n_fail = 0;

   // window-level reference state for the RD_LAT=1 instance
   int k       = 0;
   int inc_cnt = 0;
   int tx_cnt  = 0;
   logic p_vld, p_rdy, p_abort;
   logic [3:0] p_col, p_row;

   always #5 clk = ~clk;

   l1_rd_ctrl #(.WIN_COLS(C), .WIN_ROWS(R), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst), .frame_go(frame_go), .l1_rd(l1_rd), .win_rdy(win_rdy),
      .l2_done(l2_done), .abort(abort), .addr_rd_inc(a_inc), .tx_done(a_txd),
      .win_vld(a_vld), .win_last(a_last), .win_col(a_col), .win_row(a_row),
      .busy(a_busy), .err_ovr(a_err));

   l1_rd_ctrl #(.WIN_COLS(C), .WIN_ROWS(R), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .frame_go(frame_go), .l1_rd(l1_rd), .win_rdy(win_rdy),
      .l2_done(l2_done), .abort(abort), .addr_rd_inc(b_inc), .tx_done(b_txd),
      .win_vld(b_vld), .win_last(b_last), .win_col(b_col), .win_row(b_row),
      .busy(b_busy), .err_ovr(b_err));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      frame_go = 1'b1;
      cyc();
      frame_go = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; frame_go = 1'b0; l1_rd = 1'b0; win_rdy = 1'b0; l2_done = 1'b0; abort = 1'b0;
      repeat (3) cyc();
      chk("rst_a", {a_inc, a_txd, a_vld, a_last, a_col, a_row, a_busy, a_err}, 0);
      chk("rst_b", {b_inc, b_txd, b_vld, b_last, b_col, b_row, b_busy, b_err}, 0);
      rst = 1'b0;
   endtask

   task automatic run_to(input int n, input int budget);
      for (int c = 0; c < budget && inc_cnt < n; c++) cyc();
   endtask

   task automatic wait_vld(input int budget);
      for (int c = 0; c < budget && !a_vld; c++) cyc();
   endtask

   task automatic finish_frame(input string tag);
      l2_done = 1'b1;
      cyc();
      l2_done = 1'b0;
      chk({tag, "_txd1"}, a_txd, 1);
      cyc();
      chk({tag, "_txd0"}, a_txd, 0);
      chk({tag, "_idle"}, a_busy, 0);
      chk({tag, "_pos0"}, {a_col, a_row}, 0);
   endtask

   // Window-sequence reference: expected raster position, handshake rules, hold-while-stalled.
   always @(negedge clk) begin
      if (rst) begin
         k = 0; inc_cnt = 0; tx_cnt = 0;
         p_vld = 1'b0; p_rdy = 1'b0; p_abort = 1'b0; p_col = '0; p_row = '0;
      end else begin
         chk("inc_rule", a_inc, a_vld & win_rdy & ~abort);
         if (a_vld) begin
            chk("col", a_col, k % C);
            chk("row", a_row, k / C);
            chk("last", a_last, k == N - 1);
         end
         if (p_vld && p_rdy && !p_abort) chk("bubble", a_vld, 0);
         if (p_vld && !p_rdy && !p_abort) begin
            chk("hold_vld", a_vld, 1);
            chk("hold_pos", {a_col, a_row}, {p_col, p_row});
         end
         if (a_inc) inc_cnt++;
         if (a_vld && win_rdy && !abort) k++;
         if (a_txd) begin
            tx_cnt++;
            k = 0;
         end
         p_vld = a_vld; p_rdy = win_rdy; p_abort = abort; p_col = a_col; p_row = a_row;
      end
   end

   initial begin
      int first, lastc, n3, prev;
      logic [3:0] sc, sr;

      // 1: full frame at full throughput
      do_reset();
      go();
      l1_rd = 1'b1; win_rdy = 1'b1;
      first = -1; lastc = -1;
      for (int c = 0; c < 2000 && inc_cnt < N; c++) begin
         @(negedge clk);
         if (a_inc) begin
            if (first < 0) first = c;
            lastc = c;
         end
         cyc();
      end
      chk("t1_count", inc_cnt, N);
      chk("t1_span", lastc - first, (N - 1) * 3);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t1_drain_txd", a_txd, 0);
         chk("t1_drain_busy", a_busy, 1);
      end
      finish_frame("t1");
      chk("t1_txcnt", tx_cnt, 1);

      // 2: backpressure, 4 stall cycles per window
      do_reset();
      go();
      l1_rd = 1'b1; win_rdy = 1'b0;
      for (int w = 0; w < N; w++) begin
         wait_vld(20);
         chk("t2_vld", a_vld, 1);
         chk("t2_col", a_col, w % C);
         chk("t2_row", a_row, w / C);
         sc = a_col; sr = a_row;
         for (int s = 0; s < 4; s++) begin
            cyc();
            chk("t2_stall_vld", a_vld, 1);
            chk("t2_stall_pos", {a_col, a_row}, {sc, sr});
         end
         win_rdy = 1'b1;
         cyc();
         win_rdy = 1'b0;
      end
      chk("t2_count", inc_cnt, N);
      finish_frame("t2");

      // 3: data starvation after window 12
      do_reset();
      go();
      l1_rd = 1'b1; win_rdy = 1'b1;
      for (int c = 0; c < 200 && inc_cnt < 12; c++) begin
         @(negedge clk);
         cyc();
      end
      l1_rd = 1'b0;
      chk("t3_count12", inc_cnt, 12);
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("t3_starve_vld", a_vld, 0);
         chk("t3_starve_inc", a_inc, 0);
         chk("t3_starve_busy", a_busy, 1);
      end
      l1_rd = 1'b1;
      wait_vld(10);
      chk("t3_resume_vld", a_vld, 1);
      chk("t3_resume_pos", {a_col, a_row}, {4'd1, 4'd1});

      // 4: abort in PRES with a same-cycle handshake
      do_reset();
      go();
      l1_rd = 1'b1; win_rdy = 1'b1;
      run_to(3, 100);
      win_rdy = 1'b0;
      wait_vld(10);
      chk("t4_pre_pos", {a_col, a_row}, {4'd3, 4'd0});
      abort = 1'b1; win_rdy = 1'b1;
      @(negedge clk);
      chk("t4_no_inc", a_inc, 0);
      cyc();
      abort = 1'b0; win_rdy = 1'b0;
      chk("t4_txd", a_txd, 1);
      chk("t4_vld", a_vld, 0);
      cyc();
      chk("t4_txd_end", a_txd, 0);
      chk("t4_idle", a_busy, 0);
      chk("t4_count", inc_cnt, 3);
      go();
      wait_vld(10);
      chk("t4_restart_pos", {a_vld, a_col, a_row}, {1'b1, 4'd0, 4'd0});

      // 5: overrun flag
      do_reset();
      go();
      chk("t5_err_clean", a_err, 0);
      l1_rd = 1'b1; win_rdy = 1'b1;
      run_to(5, 100);
      go();
      chk("t5_err_set", a_err, 1);
      run_to(N, 2000);
      chk("t5_count", inc_cnt, N);
      chk("t5_err_sticky", a_err, 1);
      finish_frame("t5");
      chk("t5_err_idle", a_err, 1);
      do_reset();
      chk("t5_err_rst", a_err, 0);

      // 6: RD_LAT=3 throughput, early l2_done ignored
      go();
      l1_rd = 1'b1; win_rdy = 1'b1;
      n3 = 0; prev = -1;
      for (int c = 0; c < 1500 && n3 < N; c++) begin
         @(negedge clk);
         if (c == 22) begin
            chk("t6_early_txd", b_txd, 0);
            chk("t6_early_busy", b_busy, 1);
         end
         if (b_inc) begin
            if (prev >= 0) chk("t6_period", c - prev, 5);
            chk("t6_last", b_last, n3 == N - 1);
            n3++;
            prev = c;
         end
         cyc();
         l2_done = (c == 20);
      end
      l2_done = 1'b0;
      chk("t6_count", n3, N);
      cyc();
      l2_done = 1'b1;
      cyc();
      l2_done = 1'b0;
      chk("t6_txd", b_txd, 1);
      cyc();
      chk("t6_idle", b_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
